boolean_sweep_capture: RTL and testbench

//  Self-checking sweep stage for the combinational Boolean-function block. Upstream

---
 rtl/boolean_sweep_pkg.sv | 16 +
 rtl/lsb_priority_enc.sv | 27 ++
 rtl/boolean_sweep_capture.sv | 112 +++++++++++
 tb/tb_boolean_sweep_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/boolean_sweep_pkg.sv
// Shared definitions for the Boolean-function sweep/capture stage:
// FSM state encoding and the truth-table width helper.
package boolean_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Truth-table width for a function of n_in inputs.
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// set bit of vec, plus a flag telling whether any bit is set at all.
module lsb_priority_enc
    import boolean_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [tt_width(N_IN)-1:0] vec,
    output logic [N_IN-1:0]           idx,
    output logic                      any
);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = tt_width(N_IN) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = N_IN'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/boolean_sweep_capture.sv
// Sweep stage for a combinational Boolean block: drives every input vector for
// HOLD cycles, captures y on the last hold cycle and compares the table to exp_tt.
module boolean_sweep_capture
    import boolean_sweep_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int HOLD = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [tt_width(N_IN)-1:0] exp_tt,
    output logic [N_IN-1:0]           vec_o,
    input  logic                      y_i,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [tt_width(N_IN)-1:0] tt_o,
    output logic [N_IN-1:0]           fail_idx
);

    localparam int TT_W = tt_width(N_IN);
    localparam int HC_W = $clog2(HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [N_IN:0]   IDX_LAST  = (N_IN + 1)'(TT_W - 1);

    state_t            state, state_next;
    logic [N_IN:0]     idx;
    logic [HC_W-1:0]   hold_cnt;
    logic [TT_W-1:0]   exp_q;
    logic              hold_end;
    logic              last_vec;
    logic [N_IN-1:0]   enc_idx;
    logic              enc_any;

    lsb_priority_enc #(.N_IN(N_IN)) u_fail_enc (
        .vec (tt_o ^ exp_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        hold_end   = (hold_cnt == HOLD_LAST);
        last_vec   = (idx == IDX_LAST);
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_DRIVE;
            ST_DRIVE: if (hold_end && last_vec) state_next = ST_CHECK;
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values; reset is synchronous, sampled at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            hold_cnt <= '0;
            exp_q    <= '0;
            vec_o    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            tt_o     <= '0;
            fail_idx <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    vec_o <= '0;
                    if (start) begin
                        idx      <= '0;
                        hold_cnt <= '0;
                        tt_o     <= '0;
                        pass     <= 1'b0;
                        fail_idx <= '0;
                        exp_q    <= exp_tt;
                        busy     <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (hold_end) begin
                        tt_o[idx[N_IN-1:0]] <= y_i;
                        hold_cnt            <= '0;
                        // The last vector stays on vec_o through the CHECK cycle.
                        if (!last_vec) begin
                            idx   <= idx + 1'b1;
                            vec_o <= idx[N_IN-1:0] + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    pass     <= (tt_o == exp_q);
                    fail_idx <= enc_any ? enc_idx : '0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    vec_o    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boolean_sweep_capture.sv
// Directed bench for boolean_sweep_capture; the block under sweep is modelled
// as y = (a&b)|c, whose truth table is 8'hEA.
module tb_boolean_sweep_capture;

    localparam int N_IN = 3;
    localparam int TT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, start0, start1;
    logic [TT_W-1:0] exp_tt;
    logic [N_IN-1:0] vec0, vec1, fidx0, fidx1;
    logic            y0, y1, busy0, busy1, done0, done1, pass0, pass1;
    logic [TT_W-1:0] tt0, tt1;

    assign y0 = (vec0[2] & vec0[1]) | vec0[0];
    assign y1 = (vec1[2] & vec1[1]) | vec1[0];

    boolean_sweep_capture #(.N_IN(N_IN), .HOLD(10)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_tt(exp_tt), .vec_o(vec0),
        .y_i(y0), .busy(busy0), .done(done0), .pass(pass0), .tt_o(tt0), .fail_idx(fidx0)
    );

    boolean_sweep_capture #(.N_IN(N_IN), .HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp_tt), .vec_o(vec1),
        .y_i(y1), .busy(busy1), .done(done1), .pass(pass1), .tt_o(tt1), .fail_idx(fidx1)
    );

    // Selected-DUT view so the sweep tasks work on either build.
    bit              which;
    logic            s_done, s_busy, s_pass;
    logic [N_IN-1:0] s_vec, s_fidx;
    logic [TT_W-1:0] s_tt;
    always_comb begin
        s_done = which ? done1 : done0;
        s_busy = which ? busy1 : busy0;
        s_pass = which ? pass1 : pass0;
        s_vec  = which ? vec1  : vec0;
        s_fidx = which ? fidx1 : fidx0;
        s_tt   = which ? tt1   : tt0;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is first seen
    // (or after the cycle budget), with edges = edges after the start edge.
    task automatic run_sweep(input string tag, input logic [7:0] e, input int hold,
                             input bit glitch, input bit b2b, output int edges);
        int vec_bad;
        int busy_bad;
        int exp_vec;
        vec_bad  = 0;
        busy_bad = 0;
        exp_tt   = e;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (b2b) begin
            check({tag, ".cleared_pass"}, 32'(s_pass), 32'd0);
            check({tag, ".cleared_tt"}, 32'(s_tt), 32'd0);
        end
        edges = 0;
        forever begin
            if (edges < TT_W * hold)       exp_vec = edges / hold;
            else if (edges == TT_W * hold) exp_vec = TT_W - 1;
            else                           exp_vec = 0;
            if (32'(s_vec) != 32'(exp_vec)) vec_bad++;
            if (s_done || edges > 200) break;
            if (!s_busy) busy_bad++;
            if (glitch) begin
                if (edges == 19) start0 = 1'b1;
                if (edges == 20) start0 = 1'b0;
                if (edges == 29) exp_tt = 8'h00;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 32'(edges), 32'(TT_W * hold + 1));
        check({tag, ".vec_seq_errs"}, 32'(vec_bad), 32'd0);
        check({tag, ".busy_drop_errs"}, 32'(busy_bad), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic p, input logic [7:0] t,
                                input logic [2:0] f);
        check({tag, ".pass"}, 32'(s_pass), 32'(p));
        check({tag, ".tt_o"}, 32'(s_tt), 32'(t));
        check({tag, ".fail_idx"}, 32'(s_fidx), 32'(f));
        check({tag, ".busy_at_done"}, 32'(s_busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] exp_tt;
        logic       pass;
        logic [7:0] tt;
        logic [2:0] fidx;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int edges;
        int done_seen;

        tbl[0] = '{8'hEA, 1'b1, 8'hEA, 3'd0};
        tbl[1] = '{8'hEB, 1'b0, 8'hEA, 3'd0};
        tbl[2] = '{8'h6A, 1'b0, 8'hEA, 3'd7};
        tbl[3] = '{8'h00, 1'b0, 8'hEA, 3'd1};
        tbl[4] = '{8'hFF, 1'b0, 8'hEA, 3'd0};
        tbl[5] = '{8'hAA, 1'b0, 8'hEA, 3'd6};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        exp_tt = 8'h00;
        which  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.dut0_outputs", {vec0, busy0, done0, pass0, tt0, fidx0}, 32'd0);
        check("reset.dut1_outputs", {vec1, busy1, done1, pass1, tt1, fidx1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full sweeps against a range of expected tables.
        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            run_sweep(tag, tbl[i].exp_tt, 10, 1'b0, 1'b0, edges);
            check_result(tag, tbl[i].pass, tbl[i].tt, tbl[i].fidx);
            @(negedge clk);
            check({tag, ".done_pulse"}, 32'(s_done), 32'd0);
            check({tag, ".tt_held"}, 32'(s_tt), 32'(tbl[i].tt));
        end

        // start re-pulsed and exp_tt changed mid-sweep: both must be ignored.
        run_sweep("ignore", 8'hEA, 10, 1'b1, 1'b0, edges);
        check_result("ignore", 1'b1, 8'hEA, 3'd0);
        @(negedge clk);

        // Back-to-back: second start lands in the done cycle.
        run_sweep("b2b_first", 8'hEB, 10, 1'b0, 1'b0, edges);
        check_result("b2b_first", 1'b0, 8'hEA, 3'd0);
        run_sweep("b2b_second", 8'hEA, 10, 1'b0, 1'b1, edges);
        check_result("b2b_second", 1'b1, 8'hEA, 3'd0);
        @(negedge clk);

        // Reset in the middle of a sweep aborts it with no done pulse.
        exp_tt = 8'hEA;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (36) @(negedge clk);
        check("midreset.vec_before", 32'(vec0), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset.outputs", {vec0, busy0, done0, pass0, tt0, fidx0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (done0) done_seen++;
        end
        check("midreset.no_done", 32'(done_seen), 32'd0);
        run_sweep("midreset_restart", 8'hEA, 10, 1'b0, 1'b0, edges);
        check_result("midreset_restart", 1'b1, 8'hEA, 3'd0);
        @(negedge clk);

        // HOLD=1 build.
        which = 1'b1;
        run_sweep("hold1", 8'hEA, 1, 1'b0, 1'b0, edges);
        check_result("hold1", 1'b1, 8'hEA, 3'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
